dsp_z_accum: RTL
================

# dsp_z_accum

Downstream consumer of the `dsp_t1_sim` multiplier output `z_o`. It accumulates a frame of signed 38-bit products into a wide accumulator, then applies an arithmetic right shift, optional rounding and signed saturation. It presents one narrowed result per frame over a valid/ready handshake. It is the reduction stage for dot-product and FIR datapaths built on the k6n10f DSP when the DSP runs in plain multiply mode (`OUTPUT_SELECT` = 0).

## Interface
- `Z_WIDTH`, 38: product width; matches DSP `z_o`.
- `ACC_WIDTH`, 48: accumulator width; must be greater than `Z_WIDTH`.
- `OUT_WIDTH`, 20: result width (signed).
- `CNT_WIDTH`, 8: beat-counter width.

- `clock_i` in 1: clock; single clock domain.
- `reset_i` in 1: reset, synchronous, active-high.
- `z_i` in `Z_WIDTH`: signed product from the DSP.
- `z_valid_i` in 1: `z_i` valid.
- `z_last_i` in 1: final beat of the frame.
- `shift_i` in 6: right-shift amount; sampled on the first beat of a frame; values ≥ `ACC_WIDTH` are treated as `ACC_WIDTH`−1.
- `z_ready_o` out 1: block accepts a beat.
- `out_data_o` out `OUT_WIDTH`: signed result.
- `out_sat_o` out 1: result was clamped.
- `out_count_o` out `CNT_WIDTH`: beats in the frame; saturates at all-ones.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: downstream accepts the result.

## Operation
- The FSM has two states:
  - **ACCUM**: `z_ready_o`=1.
  - **HOLD**: `z_ready_o`=0, `out_valid_o`=1.
- A beat is accepted when `z_valid_i & z_ready_o`.
  - First beat of a frame: accumulator ← sext(`z_i`); count ← 1; shift register ← `shift_i`.
  - Later beats: accumulator ← accumulator + sext(`z_i`), modulo 2^`ACC_WIDTH`; count increments, saturating.
- On an accepted beat with `z_last_i`=1:
  - final = accumulator + sext(`z_i`), or sext(`z_i`) alone for a 1-beat frame.
  - The shift, round and saturate result is registered into `out_data_o`, `out_sat_o` and `out_count_o`.
  - FSM → HOLD.
- Arithmetic:
  - Intermediates are computed in `ACC_WIDTH`+1 bits to prevent overflow.
  - shifted = (final + r) >>> s, where r = 2^(s−1) if s > 0, else 0 (round half toward +∞).
  - Saturation: shifted > 2^(`OUT_WIDTH`−1)−1 gives the max value and `out_sat_o`=1. Shifted < −2^(`OUT_WIDTH`−1) gives the min value and `out_sat_o`=1.
- HOLD: outputs stay stable until `out_ready_i`=1, then FSM → ACCUM.
- `z_ready_o` stays 0 during the handshake cycle, so there is no same-cycle restart.
- Accumulator overflow (more than 2^(`ACC_WIDTH`−`Z_WIDTH`) full-scale beats) wraps silently and is not flagged.
- `z_valid_i`=0 inside a frame inserts bubbles; accumulator and count hold.

## Timing
- Reset values: state ACCUM; `z_ready_o`=1 from the cycle after reset; `out_valid_o`=0; `out_data_o`=0; `out_sat_o`=0; `out_count_o`=0; accumulator=0.
- Latency: last beat accepted at cycle t → `out_valid_o`=1 at t+1.
- Next beat can be accepted at the earliest the cycle after the output handshake.
- Throughput for a 1-beat frame with `out_ready_i` tied high: one result per 2 cycles.
- Reset mid-frame or during HOLD: the partial frame and any pending result are discarded; all outputs return to reset values the next cycle.
- `z_i`, `z_last_i` and `shift_i` are ignored while `z_ready_o`=0.

## Configuration
- `DSP_Z_ACCUM_ROUND_EN`:
  - Defined: r is added as specified in Operation.
  - Undefined: r = 0, giving pure arithmetic-shift truncation toward −∞.
  - All other behaviour is identical.

## Structure
- Package `dsp_z_accum_pkg`: FSM state enum (`ACCUM`, `HOLD`) and default width constants for Z, ACC, OUT and CNT.
- Sub-module `dsp_z_accum_rndsat`: combinational shift, round and saturate from the final sum and s to result and sat. The round macro is confined to this sub-module.

## Test plan
- **Single beat**: z=100, last, shift=0 → one cycle later: out=100, count=1, sat=0.
- **Three-beat frame with rounding**: beats 1000, −249, 7 (last), shift=2, sum=758 → out=190 with the macro, 189 without; count=3.
- **Negative rounding**: single beat z=−6, shift=2 → out=−1 with the macro, −2 without.
- **Saturation**:
  - z=2^36, shift=0 → out=524287, sat=1.
  - z=−2^37 → out=−524288, sat=1.
- **Backpressure**: result pending, `out_ready_i`=0 for 5 cycles → out held stable, `z_ready_o`=0, no beats consumed. After the handshake, `z_ready_o`=1 the next cycle and the following frame is correct.
- **Reset mid-frame**: assert reset after 2 accepted beats → all outputs go to reset values. Then a frame with a single beat 5 (last) → out=5, count=1.

Source files
------------

// File: rtl/dsp_z_accum_pkg.sv
// Shared types and default widths for the DSP product accumulator.
package dsp_z_accum_pkg;

  localparam int unsigned ZWidthDef   = 38;
  localparam int unsigned AccWidthDef = 48;
  localparam int unsigned OutWidthDef = 20;
  localparam int unsigned CntWidthDef = 8;
  localparam int unsigned ShiftWidth  = 6;

  typedef enum logic [0:0] {
    StAccum,
    StHold
  } state_e;

endpackage

// File: rtl/dsp_z_accum_rndsat.sv
// Combinational arithmetic shift, optional round-half-up and signed saturation.
// Rounding is enabled by defining DSP_Z_ACCUM_ROUND_EN.
module dsp_z_accum_rndsat
  import dsp_z_accum_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = AccWidthDef,
  parameter int unsigned OUT_WIDTH = OutWidthDef
) (
  input  logic [ACC_WIDTH-1:0]  sum_i,
  input  logic [ShiftWidth-1:0] shamt_i,
  output logic [OUT_WIDTH-1:0]  data_o,
  output logic                  sat_o
);

  // One guard bit so adding the rounding constant can never overflow.
  localparam int unsigned W = ACC_WIDTH + 1;
  localparam logic signed [W-1:0] MaxVal = {{(W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [W-1:0] MinVal = ~MaxVal;

  logic signed [W-1:0] ext;
  logic signed [W-1:0] rnd;
  logic signed [W-1:0] shifted;

  always_comb begin
    ext = $signed({sum_i[ACC_WIDTH-1], sum_i});
    rnd = '0;
`ifdef DSP_Z_ACCUM_ROUND_EN
    if (shamt_i != '0) begin
      rnd = W'(1) << (shamt_i - 1'b1);
    end
`endif
    shifted = (ext + rnd) >>> shamt_i;

    sat_o  = 1'b0;
    data_o = shifted[OUT_WIDTH-1:0];
    if (shifted > MaxVal) begin
      sat_o  = 1'b1;
      data_o = MaxVal[OUT_WIDTH-1:0];
    end else if (shifted < MinVal) begin
      sat_o  = 1'b1;
      data_o = MinVal[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/dsp_z_accum.sv
// Frame accumulator for DSP z_o products with shift/round/saturate and a valid/ready result port.
// Optional rounding macro: DSP_Z_ACCUM_ROUND_EN (handled inside dsp_z_accum_rndsat).
module dsp_z_accum
  import dsp_z_accum_pkg::*;
#(
  parameter int unsigned Z_WIDTH   = ZWidthDef,
  parameter int unsigned ACC_WIDTH = AccWidthDef,
  parameter int unsigned OUT_WIDTH = OutWidthDef,
  parameter int unsigned CNT_WIDTH = CntWidthDef
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [Z_WIDTH-1:0]    z_i,
  input  logic                  z_valid_i,
  input  logic                  z_last_i,
  input  logic [ShiftWidth-1:0] shift_i,
  output logic                  z_ready_o,
  output logic [OUT_WIDTH-1:0]  out_data_o,
  output logic                  out_sat_o,
  output logic [CNT_WIDTH-1:0]  out_count_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  state_e                  state_q, state_d;
  logic [ACC_WIDTH-1:0]    acc_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [ShiftWidth-1:0]   shift_q;
  logic [OUT_WIDTH-1:0]    out_data_q;
  logic                    out_sat_q;
  logic [CNT_WIDTH-1:0]    out_count_q;

  logic                    accept;
  logic                    first;
  logic [ACC_WIDTH-1:0]    z_ext;
  logic [ACC_WIDTH-1:0]    sum_d;
  logic [CNT_WIDTH-1:0]    cnt_d;
  logic [ShiftWidth-1:0]   shift_sel;
  logic [ShiftWidth-1:0]   shift_eff;
  logic [OUT_WIDTH-1:0]    rs_data;
  logic                    rs_sat;

  assign z_ready_o   = (state_q == StAccum);
  assign out_valid_o = (state_q == StHold);
  assign out_data_o  = out_data_q;
  assign out_sat_o   = out_sat_q;
  assign out_count_o = out_count_q;

  // A zero beat count marks the start of a frame; the count saturates, so it never wraps to 0.
  always_comb begin
    accept    = z_valid_i & z_ready_o;
    first     = (cnt_q == '0);
    z_ext     = {{(ACC_WIDTH - Z_WIDTH){z_i[Z_WIDTH-1]}}, z_i};
    sum_d     = first ? z_ext : acc_q + z_ext;
    cnt_d     = first ? CNT_WIDTH'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
    shift_sel = first ? shift_i : shift_q;
    shift_eff = (shift_sel >= ShiftWidth'(ACC_WIDTH)) ? ShiftWidth'(ACC_WIDTH - 1) : shift_sel;
  end

  dsp_z_accum_rndsat #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_rndsat (
    .sum_i  (sum_d),
    .shamt_i(shift_eff),
    .data_o (rs_data),
    .sat_o  (rs_sat)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (accept && z_last_i) state_d = StHold;
      StHold:  if (out_ready_i) state_d = StAccum;
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (z_last_i) begin
          acc_q       <= '0;
          cnt_q       <= '0;
          out_data_q  <= rs_data;
          out_sat_q   <= rs_sat;
          out_count_q <= cnt_d;
        end else begin
          acc_q <= sum_d;
          cnt_q <= cnt_d;
          if (first) shift_q <= shift_i;
        end
      end
    end
  end

endmodule
